dff_pipe: RTL and testbench
===========================

# dff_pipe

Parametrised successor to the single-bit D flip-flop: a WIDTH-bit, DEPTH-stage registered delay line with per-stage valid tracking, a global stall enable, a synchronous flush, and an occupancy count. It sits between the stimulus interface and the DUT-side datapath wherever a fixed, stallable latency is needed. It also serves as the next verification target after the plain DFF.

## Interface
- WIDTH, 8, data bits per stage (≥1)
- DEPTH, 4, number of register stages (≥1)
- RST_VAL, 0, data value loaded into every stage on reset and on flush
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-low reset
- en  input  1  advance enable; 0 = stall (all stages hold)
- flush  input  1  synchronous clear of all stages
- d  input  WIDTH  data into stage 0
- d_valid  input  1  qualifies d
- err_inject  input  1  flips the stored parity bit of the word captured this cycle (parity build only)
- q  output  WIDTH  data of stage DEPTH-1
- q_valid  output  1  valid bit of stage DEPTH-1
- occupancy  output  $clog2(DEPTH+1)  number of stages whose valid bit is set
- tap  output  DEPTH*WIDTH  all stage data; stage i at bits [i*WIDTH +: WIDTH]
- parity_err  output  1  parity mismatch on the output stage

## Operation
- Stage i holds data_i, valid_i and (parity build only) par_i.
- Reset (rst=0, asynchronous):
  - all data_i = RST_VAL
  - all valid_i = 0, par_i = 0
  - q = RST_VAL, q_valid = 0, occupancy = 0, parity_err = 0
- Priority per rising edge: flush > en > hold.
- flush=1:
  - all data_i = RST_VAL, all valid_i = 0, occupancy = 0
  - d and d_valid on that edge are dropped, regardless of en
- en=1, flush=0:
  - data_0 ← d, valid_0 ← d_valid
  - data_i ← data_{i-1} and valid_i ← valid_{i-1}, for i = 1..DEPTH-1
  - the old stage DEPTH-1 content is discarded
- en=0, flush=0: every stage holds; d and d_valid are ignored.
- Data advances whether or not valid is set. Invalid stages carry data but are never counted.
- occupancy is registered and equals the popcount of valid_i after the edge. It is computed incrementally:
  - add 1 if d_valid enters
  - subtract 1 if valid_{DEPTH-1} leaves
  - a simultaneous enter and leave leaves it unchanged
  - range 0..DEPTH, never wraps
- DEPTH=1: stage 0 is both input and output stage.

## Timing
- Latency: with en held high, d sampled at edge N appears on q/q_valid after edge N+DEPTH-1. That is DEPTH edges from presentation, counting the capture edge.
- Each en=0 cycle adds exactly one cycle of latency to every word in flight.
- q, q_valid, tap, occupancy and parity_err are all direct register outputs; there is no combinational path from any input.
- Reset mid-stream clears everything immediately and asynchronously. The first capture occurs on the first rising edge after rst deasserts.
- flush and reset do not depend on en.

## Configuration
- Macro: DFF_PIPE_PARITY_EN.
- Defined:
  - each stage stores par_i
  - on capture, par_0 ← ^d ^ err_inject
  - par_i shifts, holds and clears with data_i
  - parity_err is registered and equals valid_{DEPTH-1} & (par_{DEPTH-1} != ^data_{DEPTH-1}), evaluated on the same edge the word reaches the output stage
- Not defined:
  - par_i registers are not built
  - err_inject is ignored
  - parity_err is tied to 0
- The port list is identical in both builds.

## Test plan
- Reset: hold rst=0 for 20 ns while driving d=8'hFF, d_valid=1, en=1 → q=0, q_valid=0, occupancy=0 throughout; the first capture occurs on the first edge after release.
- Latency, DEPTH=4, en=1: drive 8'hA5 valid at edge 0, then invalid → q=8'hA5 with q_valid=1 after edge 3, q_valid=0 after edge 4; occupancy reads 1 for 4 cycles.
- Stall: stream 8'h01..8'h04 valid, drop en for 3 cycles mid-stream → the output order is preserved, each word is delayed by exactly 3 cycles, and occupancy holds constant during the stall.
- Flush: with 4 valid words in flight, assert flush with en=1 and d_valid=1 → on the next edge occupancy=0, q_valid=0, tap is all RST_VAL, and the input word is dropped.
- Full and simultaneous events: stream continuous valid words → occupancy saturates at 4 and stays there (enter and leave on the same edge); it never reads 5 or wraps.
- Parity (DFF_PIPE_PARITY_EN defined): send 8'h3C with err_inject=1, then 8'h3C clean → parity_err=1 only in the cycle the first word is on q, and 0 for the second. Without the macro, parity_err stays 0.

Source files
------------

// File: rtl/dff_pipe.sv
// dff_pipe: stallable, flushable WIDTH x DEPTH delay line with per-stage valid bits and a registered occupancy count.
// Define DFF_PIPE_PARITY_EN to add a per-stage parity bit and an output-stage parity check.
module dff_pipe #(
    parameter int               WIDTH   = 8,
    parameter int               DEPTH   = 4,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         en,
    input  logic                         flush,
    input  logic [WIDTH-1:0]             d,
    input  logic                         d_valid,
    input  logic                         err_inject,
    output logic [WIDTH-1:0]             q,
    output logic                         q_valid,
    output logic [$clog2(DEPTH+1)-1:0]   occupancy,
    output logic [DEPTH*WIDTH-1:0]       tap,
    output logic                         parity_err
);
    localparam int OW = $clog2(DEPTH+1);

    logic [DEPTH-1:0][WIDTH-1:0] data_q, data_d;
    logic [DEPTH-1:0]            valid_q, valid_d;
    logic [OW-1:0]               occ_q, occ_d;

    always_comb begin
        data_d  = data_q;
        valid_d = valid_q;
        occ_d   = occ_q;
        if (flush) begin
            data_d  = {DEPTH{RST_VAL}};
            valid_d = '0;
            occ_d   = '0;
        end else if (en) begin
            data_d[0]  = d;
            valid_d[0] = d_valid;
            for (int i = 1; i < DEPTH; i++) begin
                data_d[i]  = data_q[i-1];
                valid_d[i] = valid_q[i-1];
            end
            // enter and leave on the same edge cancel, so the count stays within 0..DEPTH
            occ_d = occ_q + OW'(d_valid) - OW'(valid_q[DEPTH-1]);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            data_q  <= {DEPTH{RST_VAL}};
            valid_q <= '0;
            occ_q   <= '0;
        end else begin
            data_q  <= data_d;
            valid_q <= valid_d;
            occ_q   <= occ_d;
        end
    end

    assign q         = data_q[DEPTH-1];
    assign q_valid   = valid_q[DEPTH-1];
    assign occupancy = occ_q;
    assign tap       = data_q;

`ifdef DFF_PIPE_PARITY_EN
    logic [DEPTH-1:0] par_q, par_d;
    logic             perr_q, perr_d;

    always_comb begin
        par_d = par_q;
        if (flush) begin
            par_d = '0;
        end else if (en) begin
            par_d[0] = ^d ^ err_inject;
            for (int i = 1; i < DEPTH; i++) begin
                par_d[i] = par_q[i-1];
            end
        end
        // checked on the next-state so the flag appears with the word on q
        perr_d = valid_d[DEPTH-1] & (par_d[DEPTH-1] != ^data_d[DEPTH-1]);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            par_q  <= '0;
            perr_q <= 1'b0;
        end else begin
            par_q  <= par_d;
            perr_q <= perr_d;
        end
    end

    assign parity_err = perr_q;
`else
    logic unused_err_inject;
    assign unused_err_inject = err_inject;
    assign parity_err        = 1'b0;
`endif
endmodule

// File: tb/tb_dff_pipe.sv
// tb_dff_pipe: scoreboard bench for dff_pipe; each captured word is tagged with its advance index
// and must appear on q exactly DEPTH-1 advances later.
module tb_dff_pipe;
    localparam int W = 8;
    localparam int D = 4;
`ifdef DFF_PIPE_PARITY_EN
    localparam bit PAR = 1'b1;
`else
    localparam bit PAR = 1'b0;
`endif

    logic           clk = 1'b0, rst = 1'b0, en = 1'b0, flush = 1'b0, d_valid = 1'b0, err_inject = 1'b0;
    logic [W-1:0]   d = '0;
    logic [W-1:0]   q;
    logic           q_valid, parity_err;
    logic [2:0]     occupancy;
    logic [D*W-1:0] tap;

    typedef struct {
        logic [W-1:0] v;
        logic         e;
        int           a;
    } ent_t;

    ent_t sb[$];
    int   adv    = 0;
    int   n_chk  = 0;
    int   n_pass = 0;

    dff_pipe #(.WIDTH(W), .DEPTH(D), .RST_VAL('0)) dut (
        .clk(clk), .rst(rst), .en(en), .flush(flush), .d(d), .d_valid(d_valid),
        .err_inject(err_inject), .q(q), .q_valid(q_valid), .occupancy(occupancy),
        .tap(tap), .parity_err(parity_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    endtask

    task automatic expect_out();
        logic due;
        due = sb.size() > 0 && sb[0].a + D - 1 == adv;
        chk("q_valid", q_valid, due);
        if (due) chk("q", q, sb[0].v);
        chk("parity_err", parity_err, due && PAR && sb[0].e);
        chk("occupancy", occupancy, sb.size());
    endtask

    task automatic step(input logic e_, input logic f_, input logic dv_, input logic [W-1:0] d_, input logic ei_);
        en = e_; flush = f_; d_valid = dv_; d = d_; err_inject = ei_;
        @(posedge clk);
        if (f_) sb.delete();
        else if (e_) begin
            if (sb.size() > 0 && sb[0].a + D - 1 == adv) void'(sb.pop_front());
            adv++;
            if (dv_) sb.push_back('{d_, ei_, adv});
        end
        @(negedge clk);
        expect_out();
    endtask

    initial begin
        rst = 1'b0; d = 8'hFF; d_valid = 1'b1; en = 1'b1;
        repeat (2) begin
            @(negedge clk);
            chk("rst_q", q, 0);
            chk("rst_q_valid", q_valid, 0);
            chk("rst_occ", occupancy, 0);
            chk("rst_tap", tap, 0);
            chk("rst_perr", parity_err, 0);
        end
        rst = 1'b1;
        step(1, 0, 1, 8'hFF, 0);
        for (int i = 0; i < 5; i++) step(1, 0, 0, 8'h00, 0);
        step(1, 0, 1, 8'hA5, 0);
        for (int i = 0; i < 5; i++) step(1, 0, 0, 8'h00, 0);
        for (int i = 1; i <= 4; i++) step(1, 0, 1, W'(i), 0);
        for (int i = 0; i < 3; i++) step(0, 0, 1, 8'hEE, 0);
        for (int i = 0; i < 6; i++) step(1, 0, 0, 8'h00, 0);
        for (int i = 0; i < 4; i++) step(1, 0, 1, W'(8'h10 + i), 0);
        step(1, 1, 1, 8'h77, 0);
        chk("flush_tap", tap, 0);
        step(1, 0, 0, 8'h00, 0);
        for (int i = 0; i < 10; i++) step(1, 0, 1, W'(8'h40 + i), 0);
        step(1, 0, 1, 8'h3C, 1);
        step(1, 0, 1, 8'h3C, 0);
        for (int i = 0; i < 5; i++) step(1, 0, 0, 8'h00, 0);
        @(posedge clk);
        #2 rst = 1'b0;
        #1;
        chk("async_rst_q_valid", q_valid, 0);
        chk("async_rst_occ", occupancy, 0);
        sb.delete();
        @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < 400; i++)
            step($urandom_range(3, 0) != 0, $urandom_range(24, 0) == 0, $urandom_range(2, 0) != 0,
                 W'($urandom), $urandom_range(5, 0) == 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
